dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the word depth (1024 words).
REQ-002 SHALL have parameter WAIT, default 2, range 0..15, meaning wait cycles inserted before the response.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  request strobe from the M-stage initiator.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port be  input  4  store byte enables; be[i] selects wdata[8i+7:8i].
REQ-009 SHALL have port wdata  input  32  store data.
REQ-010 SHALL have port busy  output  1  high while a transaction is outstanding.
REQ-011 SHALL have port ready  output  1  one-cycle response strobe.
REQ-012 SHALL have port rdata  output  32  load data, valid only while ready=1.
REQ-013 SHALL have port err  output  1  error flag, valid only while ready=1.

Function
REQ-014 SHALL implement states IDLE, WAIT_S, RESP.
REQ-015 SHALL accept a request only in IDLE with req=1; on acceptance it captures we/addr/be/wdata into internal registers; later input changes have no effect.
REQ-016 SHALL go IDLE->WAIT_S with counter=WAIT-1 when WAIT>0; IDLE->RESP when WAIT=0.
REQ-017 SHALL decrement the counter in WAIT_S and go to RESP when the counter is 0.
REQ-018 SHALL assert ready for exactly one cycle in RESP, WAIT+1 cycles after the acceptance edge; RESP->IDLE unconditionally.
REQ-019 SHALL drive busy=1 in WAIT_S and RESP, 0 in IDLE; req while busy=1 (including the ready cycle) is ignored, with no queuing.
REQ-020 SHALL index memory by addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-021 SHALL flag err when addr[31:ADDR_W+2] is nonzero, or when we=1 and be=4'b0000.
REQ-022 SHALL, on a load without error, drive rdata with the full stored word during ready, regardless of be.
REQ-023 SHALL, on a store without error, update only the enabled bytes on the clock edge that enters RESP; rdata=0 for stores.
REQ-024 SHALL, on err=1, leave memory unchanged and drive rdata=0.
REQ-025 SHALL hold rdata=0 and err=0 whenever ready=0.
REQ-026 SHALL allow back-to-back transactions: a req presented in the cycle after ready is accepted.

Reset
REQ-027 SHALL force state=IDLE, counter=0, busy=0, ready=0, err=0, rdata=0 while reset=1, independent of clk.
REQ-028 SHALL abort an outstanding transaction when reset asserts before the RESP-entry edge; no store is committed.
REQ-029 SHALL NOT clear memory on reset; memory initializes to all zeros at time 0 only.

Verification
REQ-030 Store addr=0x0000_0010, be=4'b1111, wdata=0xDEAD_BEEF, WAIT=2 -> ready=1 exactly 3 cycles after acceptance, err=0; a subsequent load of 0x10 returns 0xDEAD_BEEF.
REQ-031 Store addr=0x10, be=4'b0011, wdata=0x1234_5678 over 0xDEAD_BEEF -> a subsequent load returns 0xDEAD_5678.
REQ-032 Load addr=0x0000_1000 (out of range for ADDR_W=10) -> ready=1, err=1, rdata=0; store to the same address changes no memory word.
REQ-033 req held high continuously with alternating addresses -> one acceptance per WAIT+2 cycles; busy=1 in every non-IDLE cycle; no req accepted during ready.
REQ-034 Reset pulsed 1 cycle after accepting a store to 0x20 with wdata=0xFFFF_FFFF -> busy=0 and ready=0 immediately; a later load of 0x20 returns 0x0000_0000.
REQ-035 WAIT=0 build: load of 0x10 -> ready asserted the cycle after acceptance, rdata equal to the stored word.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder
// Word-addressed data-memory responder for an M-stage initiator. The block
// accepts one load or store at a time. It inserts WAIT wait cycles and then
// answers with a single-cycle ready strobe that carries rdata and err.
//
// Parameters
//   ADDR_W  log2 of the memory depth in 32-bit words (default 1024 words)
//   WAIT    wait cycles inserted before the response, 0..15
//
// Ports
//   clk    in   single clock, rising edge
//   reset  in   asynchronous, active-high reset
//   req    in   request strobe, sampled only while idle
//   we     in   1 = store, 0 = load
//   addr   in   byte address; bits [1:0] are ignored
//   be     in   store byte enables, be[i] selects wdata[8i+7:8i]
//   wdata  in   store data
//   busy   out  high while a transaction is outstanding
//   ready  out  one-cycle response strobe
//   rdata  out  load data, zero whenever ready is low
//   err    out  error flag, zero whenever ready is low

module dm_responder #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_S,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [29:0] word_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Storage is never reset; it starts out as all zeros.
  logic [31:0] memArray [DEPTH] = '{default: '0};

  logic              accept;
  logic              enterResp;
  logic              txWe;
  logic [29:0]       txWord;
  logic [3:0]        txBe;
  logic [31:0]       txWdata;
  logic [ADDR_W-1:0] txIdx;
  logic              txErr;
  logic              wrEn;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^addr[1:0];

  assign accept = (state_q == IDLE) && req;

  // While idle, the transaction being launched comes straight from the ports.
  // Later it comes from the captured copies. This lets a WAIT=0 build commit
  // its store and fetch its load on the acceptance edge itself.
  assign txWe    = (state_q == IDLE) ? we          : we_q;
  assign txWord  = (state_q == IDLE) ? addr[31:2]  : word_q;
  assign txBe    = (state_q == IDLE) ? be          : be_q;
  assign txWdata = (state_q == IDLE) ? wdata       : wdata_q;

  assign txIdx = txWord[ADDR_W-1:0];
  assign txErr = (|txWord[29:ADDR_W]) || (txWe && (txBe == 4'b0000));

  assign enterResp = (state_d == RESP) && (state_q != RESP);

  // While reset is held, no store may reach memory, even on a clock edge.
  assign wrEn = enterResp && txWe && !txErr && !reset;

  // Next-state logic. The counter is loaded with WAIT-1 on acceptance, so
  // WAIT_S lasts exactly WAIT cycles before RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT_S;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT_S: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control state, captured request fields and the registered response.
  // rdata/err are loaded only on the edge that enters RESP. They are cleared
  // on every other edge, so they are non-zero only during the ready cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      word_q  <= '0;
      be_q    <= 4'd0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        word_q  <= addr[31:2];
        be_q    <= be;
        wdata_q <= wdata;
      end
      if (enterResp) begin
        rdata_q <= (!txWe && !txErr) ? memArray[txIdx] : 32'd0;
        err_q   <= txErr;
      end else begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Byte-masked store, committed on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (txBe[i]) begin
          memArray[txIdx][8*i +: 8] <= txWdata[8*i +: 8];
        end
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign ready = (state_q == RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder. It drives one WAIT=2 instance and one
// WAIT=0 instance. The two instances share the data/address buses but have
// separate request strobes.

module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic        req;
  logic        req0;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic        busy, ready, err;
  logic [31:0] rdata;
  logic        busy0, ready0, err0;
  logic [31:0] rdata0;

  int vecCount;
  int missCount;

  dm_responder #(.ADDR_W(10), .WAIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .be    (be),
    .wdata (wdata),
    .busy  (busy),
    .ready (ready),
    .rdata (rdata),
    .err   (err)
  );

  dm_responder #(.ADDR_W(10), .WAIT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .req   (req0),
    .we    (we),
    .addr  (addr),
    .be    (be),
    .wdata (wdata),
    .busy  (busy0),
    .ready (ready0),
    .rdata (rdata0),
    .err   (err0)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Launches one transaction from a negedge with the DUT idle. The inputs are
  // scrambled right after acceptance, to show they were captured. The task
  // returns on the idle negedge that follows ready, with the latency in cycles.
  task automatic applyStimulus(input bit sel, input logic w, input logic [31:0] a,
                               input logic [3:0] b, input logic [31:0] d,
                               output logic [31:0] rd, output logic e, output int lat);
    logic gotReady;
    gotReady = 1'b0;
    lat = 0;
    rd = 32'd0;
    e = 1'b0;
    we = w; addr = a; be = b; wdata = d;
    if (sel) req0 = 1'b1; else req = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 20 && !gotReady; i++) begin
      @(negedge clk);
      req = 1'b0; req0 = 1'b0;
      we = ~w; addr = 32'hFFFF_FFFC; be = 4'b0000; wdata = 32'h5555_AAAA;
      if (sel ? ready0 : ready) begin
        gotReady = 1'b1;
        lat = i;
        rd = sel ? rdata0 : rdata;
        e  = sel ? err0 : err;
      end
    end
    checkOutput("readySeen", {31'd0, gotReady}, 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  logic [31:0] heldAddr [3];
  logic [31:0] heldData [3];

  initial begin
    vecCount = 0;
    missCount = 0;
    reset = 1'b0; req = 1'b0; req0 = 1'b0;
    we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    checkOutput("rst busy",  {31'd0, busy},  32'd0);
    checkOutput("rst ready", {31'd0, ready}, 32'd0);
    checkOutput("rst err",   {31'd0, err},   32'd0);
    checkOutput("rst rdata", rdata,          32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Full-word store, then readback.
    applyStimulus(0, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, rd, e, lat);
    checkOutput("st10 lat",   lat, 32'd3);
    checkOutput("st10 err",   {31'd0, e}, 32'd0);
    checkOutput("st10 rdata", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h0000_0010, 4'b0000, 32'd0, rd, e, lat);
    checkOutput("ld10 lat",   lat, 32'd3);
    checkOutput("ld10 rdata", rd, 32'hDEAD_BEEF);
    checkOutput("ld10 err",   {31'd0, e}, 32'd0);

    // Partial store over the existing word.
    applyStimulus(0, 1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678, rd, e, lat);
    checkOutput("pst err", {31'd0, e}, 32'd0);
    applyStimulus(0, 1'b0, 32'h0000_0010, 4'b1111, 32'd0, rd, e, lat);
    checkOutput("pld rdata", rd, 32'hDEAD_5678);

    // Out-of-range load and store; the store would alias word 0 if not blocked.
    applyStimulus(0, 1'b0, 32'h0000_1000, 4'b1111, 32'd0, rd, e, lat);
    checkOutput("oor ld err",   {31'd0, e}, 32'd1);
    checkOutput("oor ld rdata", rd, 32'd0);
    applyStimulus(0, 1'b1, 32'h0000_1000, 4'b1111, 32'hA5A5_A5A5, rd, e, lat);
    checkOutput("oor st err", {31'd0, e}, 32'd1);
    applyStimulus(0, 1'b0, 32'h0000_0000, 4'b1111, 32'd0, rd, e, lat);
    checkOutput("word0 rdata", rd, 32'd0);
    checkOutput("word0 err",   {31'd0, e}, 32'd0);

    // Store with no byte enables is an error and leaves memory untouched.
    applyStimulus(0, 1'b1, 32'h0000_0010, 4'b0000, 32'hFFFF_FFFF, rd, e, lat);
    checkOutput("be0 err", {31'd0, e}, 32'd1);
    // Low address bits are ignored.
    applyStimulus(0, 1'b0, 32'h0000_0013, 4'b0000, 32'd0, rd, e, lat);
    checkOutput("be0 keep", rd, 32'hDEAD_5678);

    applyStimulus(0, 1'b1, 32'h0000_0014, 4'b1111, 32'hCAFE_0014, rd, e, lat);
    checkOutput("st14 err", {31'd0, e}, 32'd0);

    // req held high: one acceptance every 4 cycles, ignored during ready,
    // and the address seen only on the idle cycle.
    heldAddr[0] = 32'h0000_0010; heldData[0] = 32'hDEAD_5678;
    heldAddr[1] = 32'h0000_0014; heldData[1] = 32'hCAFE_0014;
    heldAddr[2] = 32'h0000_0010; heldData[2] = 32'hDEAD_5678;
    req = 1'b1;
    we = 1'b0;
    be = 4'b1111;
    for (int p = 0; p < 12; p++) begin
      checkOutput($sformatf("held busy p%0d", p),  {31'd0, busy},  {31'd0, (p % 4) != 0});
      checkOutput($sformatf("held ready p%0d", p), {31'd0, ready}, {31'd0, (p % 4) == 3});
      if ((p % 4) == 3) begin
        checkOutput($sformatf("held rdata p%0d", p), rdata, heldData[p / 4]);
      end
      addr = ((p % 4) == 0) ? heldAddr[p / 4] : 32'h0000_1000;
      @(negedge clk);
    end
    checkOutput("held end busy", {31'd0, busy}, 32'd0);
    req = 1'b0;
    @(negedge clk);

    // Reset one cycle into a store aborts it with nothing committed.
    we = 1'b1; addr = 32'h0000_0020; be = 4'b1111; wdata = 32'hFFFF_FFFF;
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    checkOutput("abort busy pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort busy",  {31'd0, busy},  32'd0);
    checkOutput("abort ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0000_0020, 4'b1111, 32'd0, rd, e, lat);
    checkOutput("abort ld20", rd, 32'd0);

    // WAIT=0 instance: the response comes the cycle after acceptance.
    applyStimulus(1, 1'b1, 32'h0000_0010, 4'b1111, 32'h0BAD_F00D, rd, e, lat);
    checkOutput("w0 st lat", lat, 32'd1);
    checkOutput("w0 st err", {31'd0, e}, 32'd0);
    applyStimulus(1, 1'b0, 32'h0000_0010, 4'b0000, 32'd0, rd, e, lat);
    checkOutput("w0 ld lat",   lat, 32'd1);
    checkOutput("w0 ld rdata", rd, 32'h0BAD_F00D);

    // The WAIT=2 memory is independent and survived the reset pulse.
    applyStimulus(0, 1'b0, 32'h0000_0010, 4'b0000, 32'd0, rd, e, lat);
    checkOutput("final ld10", rd, 32'hDEAD_5678);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
